// File: rtl/array_count_compare.sv
// Purpose: sequential scan of one heap array that counts how many of its first
//          min(size, NArea) elements satisfy "elem OP key" (lt/le/gt/ge/eq/ne).
// Latency: accept at cycle 0 -> done at cycle k+2 (k >= 1), or cycle 2 when k == 0 / error.
// Backpressure: none; start is accepted only in IDLE and ignored while busy or in DONE.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               request pulse; array/size/key/mode are sampled with it
//   mem_rd_en/addr/data synchronous heap read port (data valid one cycle after en)
//   busy, done          busy from the cycle after accept until done; done is a 1-cycle pulse
//   count, error        result and error flag, held from done until the next accept

module array_count_compare #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 3,
    parameter int NArrays            = 1,
    parameter int Signed             = 0,
    parameter int AW                 = (NArrays * NArea > 1) ? $clog2(NArrays * NArea) : 1,
    parameter int CW                 = $clog2(NArea + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MemoryElementWidth-1:0] array,
    input  logic [MemoryElementWidth-1:0] size,
    input  logic [MemoryElementWidth-1:0] key,
    input  logic [2:0]                    mode,
    output logic                          mem_rd_en,
    output logic [AW-1:0]                 mem_rd_addr,
    input  logic [MemoryElementWidth-1:0] mem_rd_data,
    output logic                          busy,
    output logic                          done,
    output logic [CW-1:0]                 count,
    output logic                          error
);

    localparam int W  = MemoryElementWidth;
    // Working width for comparisons against integer parameters, wide enough
    // that neither the input nor the parameter is truncated.
    localparam int XW = (W > 32) ? W : 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    key_q, key_d;
    logic [2:0]      mode_q, mode_d;
    logic [CW-1:0]   k_q, k_d;        // clamped element count for this scan
    logic [CW-1:0]   idx_q, idx_d;    // index of the element being issued
    logic [CW-1:0]   acc_q, acc_d;
    logic            err_q, err_d;    // error pending, published at DONE
    logic            rd_vld_q, rd_vld_d;
    logic            mem_rd_en_q, mem_rd_en_d;
    logic [AW-1:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   count_q, count_d;
    logic            error_q, error_d;

    // Request decode (only meaningful in IDLE with start high).
    logic [XW-1:0]   array_x, size_x;
    logic            req_bad;
    logic [CW-1:0]   req_k;
    logic [AW-1:0]   req_base;

    always_comb begin
        array_x  = XW'(array);
        size_x   = XW'(size);
        req_bad  = (mode > 3'd5) || (array_x >= XW'(NArrays));
        req_k    = (size_x < XW'(NArea)) ? CW'(size_x) : CW'(NArea);
        req_base = AW'(array_x * XW'(NArea));
    end

    // Element-vs-key comparison. Both operands are extended by one bit so a
    // single signed compare serves both the signed and unsigned flavours.
    logic signed [W:0] elem_x, key_x;
    logic              hit;
    logic [CW-1:0]     acc_nx;

    always_comb begin
        if (Signed != 0) begin
            elem_x = {mem_rd_data[W-1], mem_rd_data};
            key_x  = {key_q[W-1], key_q};
        end else begin
            elem_x = {1'b0, mem_rd_data};
            key_x  = {1'b0, key_q};
        end
        case (mode_q)
            3'd0:    hit = (elem_x <  key_x);
            3'd1:    hit = (elem_x <= key_x);
            3'd2:    hit = (elem_x >  key_x);
            3'd3:    hit = (elem_x >= key_x);
            3'd4:    hit = (elem_x == key_x);
            3'd5:    hit = (elem_x != key_x);
            default: hit = 1'b0;
        endcase
        // Only data returned for a read we issued last cycle is counted;
        // saturation keeps the accumulator inside 0..NArea.
        acc_nx = acc_q;
        if (rd_vld_q && hit && (acc_q != CW'(NArea))) begin
            acc_nx = acc_q + CW'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        mode_d        = mode_q;
        k_d           = k_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        err_d         = err_q;
        rd_vld_d      = mem_rd_en_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_rd_addr_d = mem_rd_addr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        count_d       = count_q;
        error_d       = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    mode_d  = mode;
                    k_d     = req_k;
                    idx_d   = '0;
                    acc_d   = '0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = req_bad;
                    // Empty or illegal requests pass through DRAIN with no
                    // read outstanding so they finish on the same cycle-2 timeline.
                    if (req_bad || (req_k == '0)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d       = S_SCAN;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = req_base;
                    end
                end
            end
            S_SCAN: begin
                acc_d = acc_nx;
                if (idx_q == (k_q - CW'(1))) begin
                    state_d     = S_DRAIN;
                    mem_rd_en_d = 1'b0;
                end else begin
                    idx_d         = idx_q + CW'(1);
                    mem_rd_addr_d = mem_rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                acc_d   = acc_nx;
                count_d = acc_nx;
                error_d = err_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            mode_q        <= '0;
            k_q           <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            err_q         <= 1'b0;
            rd_vld_q      <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            mode_q        <= mode_d;
            k_q           <= k_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            rd_vld_q      <= rd_vld_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            count_q       <= count_d;
            error_q       <= error_d;
        end
    end

    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;
    assign error       = error_q;

endmodule

// File: tb/tb_array_count_compare.sv
// Purpose: directed checks of array_count_compare on two parameter sets
//          (unsigned, two arrays) and (signed, one array), each with a heap model.
// Cycle 0 is the cycle in which start is sampled; outputs are sampled on negedges.

module tb_array_count_compare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [11:0] array_i = '0;
    logic [11:0] size_i  = '0;
    logic [11:0] key_i   = '0;
    logic [2:0]  mode_i  = '0;
    logic        sel = 1'b0;

    logic        a_rd_en, a_busy, a_done, a_error;
    logic [2:0]  a_rd_addr;
    logic [11:0] a_rd_data = '0;
    logic [1:0]  a_count;
    logic        b_rd_en, b_busy, b_done, b_error;
    logic [1:0]  b_rd_addr;
    logic [11:0] b_rd_data = '0;
    logic [1:0]  b_count;

    logic [11:0] mem_a [0:7];
    logic [11:0] mem_b [0:3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    array_count_compare #(.MemoryElementWidth(12), .NArea(3), .NArrays(2), .Signed(0)) dut_a (
        .clock(clk), .reset(rst), .start(start_a), .array(array_i), .size(size_i),
        .key(key_i), .mode(mode_i), .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr),
        .mem_rd_data(a_rd_data), .busy(a_busy), .done(a_done), .count(a_count), .error(a_error)
    );

    array_count_compare #(.MemoryElementWidth(12), .NArea(3), .NArrays(1), .Signed(1)) dut_b (
        .clock(clk), .reset(rst), .start(start_b), .array(array_i), .size(size_i),
        .key(key_i), .mode(mode_i), .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
        .mem_rd_data(b_rd_data), .busy(b_busy), .done(b_done), .count(b_count), .error(b_error)
    );

    // Synchronous-read heap models.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
    end

    logic        o_rd_en, o_busy, o_done, o_error;
    logic [31:0] o_rd_addr, o_count;
    always_comb begin
        o_rd_en   = sel ? b_rd_en : a_rd_en;
        o_rd_addr = sel ? 32'(b_rd_addr) : 32'(a_rd_addr);
        o_busy    = sel ? b_busy  : a_busy;
        o_done    = sel ? b_done  : a_done;
        o_count   = sel ? 32'(b_count) : 32'(a_count);
        o_error   = sel ? b_error : a_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One request; poke > 0 raises a stray start during that cycle.
    task automatic run_op(input string tag, input int s, input int arr, input int sz,
                          input int ky, input int md, input int exp_cnt, input int exp_err,
                          input int exp_reads, input int exp_done, input int first_addr,
                          input int poke);
        int nreads;
        int done_cyc;
        sel     = (s != 0);
        array_i = 12'(arr);
        size_i  = 12'(sz);
        key_i   = 12'(ky);
        mode_i  = 3'(md);
        if (s != 0) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        nreads   = 0;
        done_cyc = -1;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, ".busy_c1"}, 32'(o_busy), 1);
            if (o_rd_en) begin
                check({tag, ".addr"}, o_rd_addr, 32'(first_addr + nreads));
                check({tag, ".read_cycle"}, 32'(c), 32'(nreads + 1));
                nreads++;
            end
            if (o_done) begin
                done_cyc = c;
                check({tag, ".busy_at_done"}, 32'(o_busy), 0);
            end
            if (c == poke) begin
                // Garbage request that must be ignored.
                array_i = 12'd1;
                key_i   = 12'd0;
                mode_i  = 3'd5;
                size_i  = 12'd3;
                if (s != 0) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        check({tag, ".done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check({tag, ".count"}, o_count, 32'(exp_cnt));
        check({tag, ".error"}, 32'(o_error), 32'(exp_err));
        check({tag, ".nreads"}, 32'(nreads), 32'(exp_reads));
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check({tag, ".idle_after"}, {30'd0, o_busy, o_done}, 0);
        check({tag, ".count_held"}, o_count, 32'(exp_cnt));
    endtask

    initial begin
        mem_a[0] = 12'd10; mem_a[1] = 12'd20; mem_a[2] = 12'd30;
        mem_a[3] = 12'd5;  mem_a[4] = 12'd1;  mem_a[5] = 12'd9;
        mem_a[6] = 12'd0;  mem_a[7] = 12'd0;
        mem_b[0] = 12'hFFF; mem_b[1] = 12'h001; mem_b[2] = 12'h800; mem_b[3] = 12'h000;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.a", {26'd0, a_rd_en, a_rd_addr, a_busy, a_done, a_error}, 0);
        check("reset.a_count", 32'(a_count), 0);
        check("reset.b", {24'd0, b_rd_en, b_rd_addr, b_busy, b_done, b_error, b_count}, 0);
        rst = 1'b0;

        //     tag        dut arr size key  md cnt err rd done addr poke
        run_op("lt",      0, 0, 3, 20,  0, 1, 0, 3, 5, 0, 0);
        run_op("le",      0, 0, 3, 20,  1, 2, 0, 3, 5, 0, 0);
        run_op("gt",      0, 0, 3, 20,  2, 1, 0, 3, 5, 0, 0);
        run_op("ge",      0, 0, 3, 20,  3, 2, 0, 3, 5, 0, 0);
        run_op("eq",      0, 0, 3, 20,  4, 1, 0, 3, 5, 0, 0);
        run_op("ne",      0, 0, 3, 20,  5, 2, 0, 3, 5, 0, 0);
        run_op("poke_c2", 0, 0, 3, 20,  0, 1, 0, 3, 5, 0, 2);
        run_op("poke_dn", 0, 0, 3, 20,  3, 2, 0, 3, 5, 0, 5);
        run_op("size0",   0, 0, 0, 20,  0, 0, 0, 0, 2, 0, 0);
        run_op("size7",   0, 0, 7, 20,  0, 1, 0, 3, 5, 0, 0);
        run_op("arr1",    0, 1, 3, 6,   0, 2, 0, 3, 5, 3, 0);
        run_op("arr2",    0, 2, 3, 6,   0, 0, 1, 0, 2, 0, 0);
        run_op("mode6",   0, 0, 3, 20,  6, 0, 1, 0, 2, 0, 0);
        run_op("ne_sat",  0, 0, 3, 0,   5, 3, 0, 3, 5, 0, 0);
        run_op("arr1_k2", 0, 1, 2, 6,   0, 2, 0, 2, 4, 3, 0);

        // Reset in the middle of a scan (count currently holds 2).
        sel = 1'b0;
        array_i = 12'd0; size_i = 12'd3; key_i = 12'd20; mode_i = 3'd1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst.ctl", {26'd0, a_rd_en, a_rd_addr, a_busy, a_done, a_error}, 0);
        check("midrst.count", 32'(a_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.quiet", {30'd0, a_rd_en, a_busy}, 0);
        run_op("post_rst", 0, 0, 3, 20, 0, 1, 0, 3, 5, 0, 0);

        // Signed-looking data on the unsigned instance.
        mem_a[0] = 12'hFFF; mem_a[1] = 12'h001; mem_a[2] = 12'h800;
        run_op("u_lt0",   0, 0, 3, 0,     0, 0, 0, 3, 5, 0, 0);
        run_op("u_gt7ff", 0, 0, 3, 12'h7FF, 2, 2, 0, 3, 5, 0, 0);

        // Signed instance.
        run_op("s_lt0",   1, 0, 3, 0,      0, 2, 0, 3, 5, 0, 0);
        run_op("s_gt0",   1, 0, 3, 0,      2, 1, 0, 3, 5, 0, 0);
        run_op("s_le_m1", 1, 0, 3, 12'hFFF, 1, 2, 0, 3, 5, 0, 0);
        run_op("s_arr1",  1, 1, 3, 0,      0, 0, 1, 0, 2, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
